// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check
//   Frame assembler / checker that sits behind a UART bit sampler. The
//   sampler supplies a validated start pulse and one strobe per later bit.
//   This block shifts in the data bits LSB-first and checks the optional
//   parity bit and the stop bit. It publishes good words and keeps a
//   saturating count of errored frames.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start_detect  : 1-cycle pulse, validated start bit (only honoured in IDLE)
//   sampled_bit   : line value, qualified by bit_valid
//   bit_valid     : 1-cycle strobe, sampled_bit is the next frame bit
//   par_en        : frame carries a parity bit (latched at start)
//   par_typ       : 0 = even, 1 = odd parity (latched at start)
//   err_clr       : synchronous clear of err_count (wins over increment)
//   rx_data       : last error-free word
//   data_valid    : 1-cycle pulse when rx_data updates
//   frame_done    : 1-cycle pulse at the end of every frame
//   parity_err    : parity mismatch in last completed frame (held)
//   stop_err      : framing error in last completed frame (held)
//   err_count     : saturating count of errored frames
//   busy          : FSM not in IDLE
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_detect,
  input  logic                  sampled_bit,
  input  logic                  bit_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  parity_err,
  output logic                  stop_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  xor_r;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_l, par_typ_l;
  logic                  par_mis;

  logic last_bit, stop_fire, stop_e, par_e, frame_err;

  assign last_bit  = (cnt == CNT_W'(DATA_WIDTH - 1));
  assign stop_fire = (state == STOP) && bit_valid;
  assign stop_e    = ~sampled_bit;
  // A stale mismatch from an earlier frame must not leak into a no-parity frame.
  assign par_e     = par_en_l & par_mis;
  assign frame_err = stop_e | par_e;
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. bit_valid in IDLE (even alongside start_detect) is dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_detect) state_nxt = DATA;
      DATA:   if (bit_valid && last_bit) state_nxt = par_en_l ? PARITY : STOP;
      PARITY: if (bit_valid) state_nxt = STOP;
      STOP:   if (bit_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      xor_r      <= 1'b0;
      shreg      <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_mis    <= 1'b0;
      rx_data    <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      stop_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;

      unique case (state)
        IDLE: if (start_detect) begin
          par_en_l  <= par_en;
          par_typ_l <= par_typ;
          cnt       <= '0;
          xor_r     <= 1'b0;
          par_mis   <= 1'b0;
        end
        DATA: if (bit_valid) begin
          shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
          xor_r <= xor_r ^ sampled_bit;
          cnt   <= cnt + 1'b1;
        end
        PARITY: if (bit_valid) begin
          par_mis <= sampled_bit ^ xor_r ^ par_typ_l;
        end
        STOP: if (bit_valid) begin
          frame_done <= 1'b1;
          parity_err <= par_e;
          stop_err   <= stop_e;
          if (!frame_err) begin
            data_valid <= 1'b1;
            rx_data    <= shreg;
          end
        end
        default: ;
      endcase

      if (err_clr)
        err_count <= '0;
      else if (stop_fire && frame_err && (err_count != {ERR_CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed + randomized bench for uart_rx_frame_check (DATA_WIDTH=8, ERR_CNT_W=2).
// Expected results come from a frame-level model: the word value, its
// parity by reduction XOR, and the stop bit value.
module tb_uart_rx_frame_check;

  localparam int DW = 8;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst, start_detect, sampled_bit, bit_valid;
  logic          par_en, par_typ, err_clr;
  logic [DW-1:0] rx_data;
  logic          data_valid, frame_done, parity_err, stop_err, busy;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // model state
  logic [DW-1:0] exp_rx  = '0;
  int            exp_cnt = 0;
  logic          exp_pe  = 1'b0;
  logic          exp_se  = 1'b0;

  uart_rx_frame_check #(.DATA_WIDTH(DW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .start_detect(start_detect), .sampled_bit(sampled_bit),
    .bit_valid(bit_valid), .par_en(par_en), .par_typ(par_typ), .err_clr(err_clr),
    .rx_data(rx_data), .data_valid(data_valid), .frame_done(frame_done),
    .parity_err(parity_err), .stop_err(stop_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rx_data"},    32'(rx_data),    32'(exp_rx));
    chk({tag, ".parity_err"}, 32'(parity_err), 32'(exp_pe));
    chk({tag, ".stop_err"},   32'(stop_err),   32'(exp_se));
    chk({tag, ".err_count"},  32'(err_count),  32'(exp_cnt));
  endtask

  // Send one frame. toggle: scramble par_en/par_typ during gaps.
  // clr: assert err_clr with the stop strobe. coinc: bit_valid alongside start.
  task automatic send_frame(input string tag, input logic [DW-1:0] d,
                            input logic pe, input logic pt, input logic pbit,
                            input logic sbit, input int maxgap, input bit toggle,
                            input bit clr, input bit coinc);
    logic bits[$];
    logic err;
    int   gap;
    par_en = pe; par_typ = pt;
    start_detect = 1'b1; bit_valid = coinc; sampled_bit = 1'b1;
    tick();
    start_detect = 1'b0; bit_valid = 1'b0;
    chk({tag, ".busy_start"}, 32'(busy), 32'd1);

    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(sbit);

    foreach (bits[i]) begin
      gap = $urandom_range(maxgap, 0);
      for (int g = 0; g < gap; g++) begin
        if (toggle) begin par_typ = ~par_typ; par_en = ~par_en; end
        // strobe-free cycle with a spurious start: must be ignored mid-frame
        start_detect = (g == 0);
        tick();
        start_detect = 1'b0;
      end
      if (i == bits.size() - 1) begin
        chk({tag, ".no_early_done"}, 32'(frame_done), 32'd0);
        chk({tag, ".busy_pre_stop"}, 32'(busy), 32'd1);
        err_clr = clr;
      end
      sampled_bit = bits[i]; bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0; err_clr = 1'b0;
    end

    // frame-level model
    exp_pe = pe && (pbit != ((^d) ^ pt));
    exp_se = !sbit;
    err    = exp_pe | exp_se;
    if (!err) exp_rx = d;
    if (clr) exp_cnt = 0;
    else if (err && exp_cnt < (1 << EW) - 1) exp_cnt++;

    chk({tag, ".frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(!err));
    chk({tag, ".busy_end"},   32'(busy),       32'd0);
    check_all(tag);
    tick();
    chk({tag, ".done_pulse"}, 32'(frame_done), 32'd0);
    chk({tag, ".dv_pulse"},   32'(data_valid), 32'd0);
    check_all({tag, ".hold"});
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          rpe, rpt, rpb, rsb;
    rst = 1'b1; start_detect = 1'b0; sampled_bit = 1'b0; bit_valid = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("reset.busy",       32'(busy),       32'd0);
    chk("reset.frame_done", 32'(frame_done), 32'd0);
    chk("reset.data_valid", 32'(data_valid), 32'd0);
    check_all("reset");
    rst = 1'b0;
    tick();

    // strobes in IDLE without a start do nothing
    sampled_bit = 1'b0; bit_valid = 1'b1; tick(); bit_valid = 1'b0;
    chk("idle_strobe.busy", 32'(busy), 32'd0);
    chk("idle_strobe.done", 32'(frame_done), 32'd0);

    // good even-parity frame
    send_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    // odd parity, same bits: parity error
    send_frame("a5_odd",  8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    // no parity, stop 0: framing error
    send_frame("3c_stop", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    // drive counter to saturation and beyond
    send_frame("sat3",    8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    send_frame("sat4",    8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
    // clear coinciding with an errored frame_done
    send_frame("clr_win", 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0);
    // start together with a strobe: strobe not consumed
    send_frame("coinc",   8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1);

    // reset mid-frame after 4 data bits
    par_en = 1'b1; par_typ = 1'b0;
    start_detect = 1'b1; tick(); start_detect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sampled_bit = i[0]; bit_valid = 1'b1; tick(); bit_valid = 1'b0;
    end
    rst = 1'b1; #1;
    exp_rx = '0; exp_cnt = 0; exp_pe = 1'b0; exp_se = 1'b0;
    chk("midrst.busy", 32'(busy), 32'd0);
    check_all("midrst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sampled_bit = 1'b1; bit_valid = 1'b1; tick(); bit_valid = 1'b0;
      chk("midrst.no_done", 32'(frame_done), 32'd0);
    end
    send_frame("after_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

    // gapped frame with par_typ/par_en toggling mid-frame
    send_frame("gap_tog",  8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1, 0, 0);
    send_frame("gap_tog2", 8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1, 0, 0);

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      rd  = 8'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      rpb = ($urandom_range(3, 0) == 0) ? ~((^rd) ^ rpt) : ((^rd) ^ rpt);
      rsb = ($urandom_range(3, 0) != 0);
      send_frame($sformatf("rnd%0d", n), rd, rpe, rpt, rpb, rsb, 5, 1'($urandom),
                 ($urandom_range(7, 0) == 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
